// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encodings, parity selector values
// and the fixed line levels of the start and stop bits.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // PAR_TYP selector values; the receiver's parity checker uses the same ones.
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  // Line levels of the framing bits.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel request side and serial line of the UART transmitter.
// master: the upstream producer; slave: the transmitter itself.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  Busy
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output Busy
  );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of the latched byte. Same rule as the receiver-side
// checker: even parity makes the total count of ones even, odd makes it odd.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Even: plain XOR reduction; odd: its complement.
  always_comb begin
    if (par_typ == PAR_EVEN) begin
      par_bit = ^data;
    end else begin
      par_bit = ~^data;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one bit per clk, frame = start, DATA_WIDTH data bits
// LSB first, optional parity, stop. TX_OUT and Busy are registered and are
// computed from the state being entered, so they change on the same edge as
// the state does.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_e             state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_typ_reg, par_typ_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;
  logic                  par_bit;

  // Parity always comes from the latched byte, never from the live inputs.
  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data   (data_reg),
    .par_typ(par_typ_reg),
    .par_bit(par_bit)
  );

  // State, counter, holding and output registers; reset drops the line high at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
      tx_reg      <= STOP_BIT;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      data_reg    <= data_next;
      par_en_reg  <= par_en_next;
      par_typ_reg <= par_typ_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
    end
  end

  // Next state plus the line level and Busy for the state being entered.
  // Requests are only accepted in IDLE and STOP; elsewhere they are dropped.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    data_next    = data_reg;
    par_en_next  = par_en_reg;
    par_typ_next = par_typ_reg;
    tx_next      = STOP_BIT;
    busy_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.Data_Valid) begin
          data_next    = bus.P_DATA;
          par_en_next  = bus.PAR_EN;
          par_typ_next = bus.PAR_TYP;
          state_next   = ST_START;
          tx_next      = START_BIT;
          busy_next    = 1'b1;
        end
      end

      ST_START: begin
        state_next = ST_DATA;
        cnt_next   = '0;
        tx_next    = data_reg[0];
        busy_next  = 1'b1;
      end

      ST_DATA: begin
        busy_next = 1'b1;
        if (cnt_reg == CNT_LAST) begin
          if (par_en_reg) begin
            state_next = ST_PARITY;
            tx_next    = par_bit;
          end else begin
            state_next = ST_STOP;
            tx_next    = STOP_BIT;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
          tx_next  = data_reg[cnt_next];
        end
      end

      ST_PARITY: begin
        state_next = ST_STOP;
        tx_next    = STOP_BIT;
        busy_next  = 1'b1;
      end

      ST_STOP: begin
        if (bus.Data_Valid) begin
          // Back-to-back: the next start bit directly follows this stop bit.
          data_next    = bus.P_DATA;
          par_en_next  = bus.PAR_EN;
          par_typ_next = bus.PAR_TYP;
          state_next   = ST_START;
          tx_next      = START_BIT;
          busy_next    = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.TX_OUT = tx_reg;
  assign bus.Busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a table of single frames with hand-computed
// line sequences, then back-to-back, ignored-request and reset-abort cases.
// A one-sample-per-clk receiver model decodes every frame on the line.
module tb_uart_tx;

  localparam int DW = 8;

  logic clk;
  logic rst;

  uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Receiver model
  typedef struct {
    logic [DW-1:0] data;
    logic          par;
    logic          stop;
  } rx_t;

  rx_t           rx_q[$];
  int            rx_phase = 0;
  logic [DW-1:0] rx_data;
  logic          rx_par;
  logic          rx_par_en = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      rx_phase = 0;
    end else if (rx_phase == 0) begin
      if (bus.TX_OUT == 1'b0) rx_phase = 1;
    end else if (rx_phase <= DW) begin
      rx_data[rx_phase-1] = bus.TX_OUT;
      rx_phase++;
    end else if (rx_par_en && rx_phase == DW + 1) begin
      rx_par = bus.TX_OUT;
      rx_phase++;
    end else begin
      rx_q.push_back('{data: rx_data, par: rx_par, stop: bus.TX_OUT});
      rx_phase = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rx(input string name, input logic [DW-1:0] d, input logic pe, input logic p);
    rx_t f;
    if (rx_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_rx: no frame decoded, expected data %h", name, d);
    end else begin
      f = rx_q.pop_front();
      check({name, "_rxdata"}, 32'(f.data), 32'(d));
      check({name, "_rxstop"}, 32'(f.stop), 32'd1);
      if (pe) check({name, "_rxpar"}, 32'(f.par), 32'(p));
    end
  endtask

  // Issue one Data_Valid pulse; returns 1 time unit after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
    @(posedge clk);
    #1;
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = 1'b1;
    rx_par_en      = pe;
    @(posedge clk);
    #1;
    bus.Data_Valid = 1'b0;
  endtask

  // Sample n consecutive line cycles, bit i = cycle i.
  task automatic capture(input int n, output logic [31:0] bits, output logic [31:0] bsy);
    bits = '0;
    bsy  = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bits[i] = bus.TX_OUT;
      bsy[i]  = bus.Busy;
    end
  endtask

  // Table: bits[i] is the line level in frame cycle i (start at bit 0).
  typedef struct {
    string     name;
    logic [7:0] data;
    logic       pe;
    logic       pt;
    int         len;
    logic [10:0] bits;
    logic       par;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] got_bits, got_busy;

    vecs[0] = '{name: "a5_nopar", data: 8'hA5, pe: 1'b0, pt: 1'b0, len: 10, bits: 11'h34A, par: 1'b0};
    vecs[1] = '{name: "a5_even",  data: 8'hA5, pe: 1'b1, pt: 1'b0, len: 11, bits: 11'h54A, par: 1'b0};
    vecs[2] = '{name: "a5_odd",   data: 8'hA5, pe: 1'b1, pt: 1'b1, len: 11, bits: 11'h74A, par: 1'b1};
    vecs[3] = '{name: "80_odd",   data: 8'h80, pe: 1'b1, pt: 1'b1, len: 11, bits: 11'h500, par: 1'b0};
    vecs[4] = '{name: "ff_even",  data: 8'hFF, pe: 1'b1, pt: 1'b0, len: 11, bits: 11'h5FE, par: 1'b0};
    vecs[5] = '{name: "00_odd",   data: 8'h00, pe: 1'b1, pt: 1'b1, len: 11, bits: 11'h600, par: 1'b1};
    vecs[6] = '{name: "55_nopar", data: 8'h55, pe: 1'b0, pt: 1'b0, len: 10, bits: 11'h2AA, par: 1'b0};

    rst            = 1'b0;
    bus.P_DATA     = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(bus.TX_OUT), 32'd1);
    check("reset_busy", 32'(bus.Busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    capture(3, got_bits, got_busy);
    check("idle_tx", got_bits, 32'h7);
    check("idle_busy", got_busy, 32'h0);
    $display("reset/idle checked");

    // Single frames; inputs are scrambled right after acceptance to show
    // that only the latched values are serialised.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].data, vecs[i].pe, vecs[i].pt);
      bus.P_DATA  = ~vecs[i].data;
      bus.PAR_EN  = ~vecs[i].pe;
      bus.PAR_TYP = ~vecs[i].pt;
      capture(vecs[i].len + 1, got_bits, got_busy);
      check({vecs[i].name, "_bits"}, got_bits, 32'(vecs[i].bits) | (32'd1 << vecs[i].len));
      check({vecs[i].name, "_busy"}, got_busy, (32'd1 << vecs[i].len) - 32'd1);
      check_rx(vecs[i].name, vecs[i].data, vecs[i].pe, vecs[i].par);
      check({vecs[i].name, "_extra"}, 32'(rx_q.size()), 32'd0);
      $display("frame %s data=%h pe=%0d pt=%0d line=%h busy=%h",
               vecs[i].name, vecs[i].data, vecs[i].pe, vecs[i].pt, got_bits, got_busy);
    end

    // Back-to-back: second request lands in the STOP cycle of the first.
    send(8'h3C, 1'b0, 1'b0);
    fork
      capture(21, got_bits, got_busy);
      begin
        repeat (9) @(posedge clk);
        #1;
        bus.P_DATA     = 8'hC3;
        bus.Data_Valid = 1'b1;
        @(posedge clk);
        #1 bus.Data_Valid = 1'b0;
      end
    join
    check("b2b_bits", got_bits, {11'd0, 1'b1, 10'h386, 10'h278});
    check("b2b_busy", got_busy, 32'h000F_FFFF);
    check_rx("b2b_first", 8'h3C, 1'b0, 1'b0);
    check_rx("b2b_second", 8'hC3, 1'b0, 1'b0);
    check("b2b_extra", 32'(rx_q.size()), 32'd0);
    $display("back-to-back 3C,C3 line=%h busy=%h", got_bits, got_busy);

    // Request during DATA is dropped.
    send(8'h00, 1'b0, 1'b0);
    fork
      capture(13, got_bits, got_busy);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.P_DATA     = 8'hFF;
        bus.Data_Valid = 1'b1;
        @(posedge clk);
        #1 bus.Data_Valid = 1'b0;
      end
    join
    check("ignore_bits", got_bits, 32'h0000_1E00);
    check("ignore_busy", got_busy, 32'h0000_03FF);
    check_rx("ignore", 8'h00, 1'b0, 1'b0);
    check("ignore_extra", 32'(rx_q.size()), 32'd0);
    $display("ignored request line=%h busy=%h", got_bits, got_busy);

    // Reset in the middle of the data bits aborts at once.
    send(8'h55, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_tx", 32'(bus.TX_OUT), 32'd1);
    check("abort_busy", 32'(bus.Busy), 32'd0);
    capture(2, got_bits, got_busy);
    check("abort_hold_tx", got_bits, 32'h3);
    check("abort_hold_busy", got_busy, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    check("abort_nofr", 32'(rx_q.size()), 32'd0);
    send(8'h55, 1'b0, 1'b0);
    capture(11, got_bits, got_busy);
    check("post_rst_bits", got_bits, 32'h0000_06AA);
    check("post_rst_busy", got_busy, 32'h0000_03FF);
    check_rx("post_rst", 8'h55, 1'b0, 1'b0);
    check("post_rst_extra", 32'(rx_q.size()), 32'd0);
    $display("reset abort then 55 line=%h busy=%h", got_bits, got_busy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
